// File: rtl/change_dispenser_if.sv
// Purpose : bundles the change_dispenser control inputs and payout/inventory outputs.
// Ports   : i_* are driven by the sale controller (master), o_* by the dispenser (slave).
// Timing  : plain signal bundle, adds no latency; pulses are single-cycle, no backpressure.
interface change_dispenser_if #(
  parameter int COIN_W = 4
);
  // Controller -> dispenser
  logic              i_start;
  logic [6:0]        i_change;
  logic              i_coin1_p;
  logic              i_coin2_p;
  logic              i_coin5_p;
  logic              i_coin10_p;
  logic              i_refill;
  // Dispenser -> controller / coin hardware
  logic              o_eject1;
  logic              o_eject2;
  logic              o_eject5;
  logic              o_eject10;
  logic              o_busy;
  logic              o_finish;
  logic              o_fail;
  logic [6:0]        o_remaining;
  logic [COIN_W-1:0] o_inv1;
  logic [COIN_W-1:0] o_inv2;
  logic [COIN_W-1:0] o_inv5;
  logic [COIN_W-1:0] o_inv10;

  modport master (
    output i_start, i_change, i_coin1_p, i_coin2_p, i_coin5_p, i_coin10_p, i_refill,
    input  o_eject1, o_eject2, o_eject5, o_eject10, o_busy, o_finish, o_fail,
    input  o_remaining, o_inv1, o_inv2, o_inv5, o_inv10
  );

  modport slave (
    input  i_start, i_change, i_coin1_p, i_coin2_p, i_coin5_p, i_coin10_p, i_refill,
    output o_eject1, o_eject2, o_eject5, o_eject10, o_busy, o_finish, o_fail,
    output o_remaining, o_inv1, o_inv2, o_inv5, o_inv10
  );
endinterface

// File: rtl/change_dispenser.sv
// Purpose : greedy 10/5/2/1 coin payout sequencer with per-denomination inventory.
// Latency : start at cycle t -> first eject at t+2 (finish at t+2 for zero change);
//           each coin takes PULSE_CYCLES high + GAP_CYCLES low + 1 select cycle.
// Backpr. : none; start while busy is ignored, inserts/refill are always accepted.
// Ports   : i_clk, i_rst (sync, active-high); bus (slave modport): start/change,
//           coin insert pulses, refill in; eject strobes, busy, finish, fail,
//           remaining and the four inventory counters out. All outputs registered.
module change_dispenser #(
  parameter int PULSE_CYCLES = 4,
  parameter int GAP_CYCLES   = 2,
  parameter int COIN_W       = 4,
  parameter int INIT_COINS   = 5
) (
  input  logic              i_clk,
  input  logic              i_rst,
  change_dispenser_if.slave bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SELECT = 2'd1;
  localparam logic [1:0] S_PULSE  = 2'd2;
  localparam logic [1:0] S_GAP    = 2'd3;

  localparam int CNT_MAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0]  P_LAST = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  G_LAST = CNT_W'(GAP_CYCLES - 1);
  localparam logic [COIN_W-1:0] INIT_V = COIN_W'(INIT_COINS);
  localparam logic [COIN_W-1:0] MAX_V  = '1;

  // Denomination index: 0 -> 1, 1 -> 2, 2 -> 5, 3 -> 10
  logic [1:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [6:0]        r_remaining;
  logic [3:0]        r_eject;
  logic              r_busy;
  logic              r_finish;
  logic              r_fail;
  logic [COIN_W-1:0] r_inv [4];

  logic [3:0] w_sel;
  logic [6:0] w_den;
  logic [3:0] w_dec;
  logic [3:0] w_ins;

  // Greedy pick: largest denomination that fits and is in stock
  always_comb begin
    w_sel = 4'b0000;
    if (r_remaining >= 7'd10 && r_inv[3] != '0)      w_sel = 4'b1000;
    else if (r_remaining >= 7'd5 && r_inv[2] != '0)  w_sel = 4'b0100;
    else if (r_remaining >= 7'd2 && r_inv[1] != '0)  w_sel = 4'b0010;
    else if (r_remaining >= 7'd1 && r_inv[0] != '0)  w_sel = 4'b0001;
  end

  always_comb begin
    w_den = 7'd0;
    if (r_eject[3])      w_den = 7'd10;
    else if (r_eject[2]) w_den = 7'd5;
    else if (r_eject[1]) w_den = 7'd2;
    else if (r_eject[0]) w_den = 7'd1;
  end

  // The coin is accounted for exactly once, on the first cycle of its strobe
  assign w_dec = (r_state == S_PULSE && r_cnt == '0) ? r_eject : 4'b0000;
  assign w_ins = {bus.i_coin10_p, bus.i_coin5_p, bus.i_coin2_p, bus.i_coin1_p};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_remaining <= 7'd0;
      r_eject     <= 4'b0000;
      r_busy      <= 1'b0;
      r_finish    <= 1'b0;
      r_fail      <= 1'b0;
    end else begin
      r_finish <= 1'b0;
      r_fail   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.i_start) begin
            r_remaining <= bus.i_change;
            r_busy      <= 1'b1;
            r_state     <= S_SELECT;
          end
        end
        S_SELECT: begin
          if (r_remaining == 7'd0) begin
            r_finish <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= S_IDLE;
          end else if (w_sel == 4'b0000) begin
            // Out of usable coins: abort, keep the amount still owed visible
            r_fail  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_eject <= w_sel;
            r_cnt   <= '0;
            r_state <= S_PULSE;
          end
        end
        S_PULSE: begin
          if (r_cnt == '0) r_remaining <= r_remaining - w_den;
          if (r_cnt == P_LAST) begin
            r_eject <= 4'b0000;
            r_cnt   <= '0;
            r_state <= S_GAP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          if (r_cnt == G_LAST) begin
            r_cnt   <= '0;
            r_state <= S_SELECT;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  // Inventory: refill beats inserts, but a same-cycle eject still removes its coin
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < 4; i++) r_inv[i] <= INIT_V;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (bus.i_refill) begin
          r_inv[i] <= INIT_V - COIN_W'(w_dec[i]);
        end else if (w_ins[i] && !w_dec[i]) begin
          if (r_inv[i] != MAX_V) r_inv[i] <= r_inv[i] + COIN_W'(1);
        end else if (!w_ins[i] && w_dec[i]) begin
          r_inv[i] <= r_inv[i] - COIN_W'(1);
        end
      end
    end
  end

  assign bus.o_eject1    = r_eject[0];
  assign bus.o_eject2    = r_eject[1];
  assign bus.o_eject5    = r_eject[2];
  assign bus.o_eject10   = r_eject[3];
  assign bus.o_busy      = r_busy;
  assign bus.o_finish    = r_finish;
  assign bus.o_fail      = r_fail;
  assign bus.o_remaining = r_remaining;
  assign bus.o_inv1      = r_inv[0];
  assign bus.o_inv2      = r_inv[1];
  assign bus.o_inv5      = r_inv[2];
  assign bus.o_inv10     = r_inv[3];

endmodule

// File: tb/tb_change_dispenser.sv
module tb_change_dispenser;
  localparam int P      = 4;
  localparam int G      = 2;
  localparam int STEP   = P + G + 1;   // strobe + gap + select cycle per coin
  localparam int INIT   = 5;
  localparam int MAXINV = 15;

  logic clk = 1'b0;
  logic rst;

  change_dispenser_if #(.COIN_W(4)) bus ();

  change_dispenser #(
    .PULSE_CYCLES(P), .GAP_CYCLES(G), .COIN_W(4), .INIT_COINS(INIT)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference inventory, index 0:1 yuan, 1:2, 2:5, 3:10
  int m_inv [4];
  int exp_den [128];
  int exp_n, exp_rem;
  bit exp_fail;

  int obs_den [128];
  int obs_start [128];
  int obs_len [128];
  int obs_n, obs_end_rel, obs_busy;
  bit obs_end_fail, obs_multi;

  int         inj_rel = -1;
  bit         inj_start, inj_refill;
  logic [6:0] inj_change;
  logic [3:0] inj_coins;
  bit         start_refill = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_inputs();
    bus.i_start = 0; bus.i_refill = 0;
    {bus.i_coin10_p, bus.i_coin5_p, bus.i_coin2_p, bus.i_coin1_p} = 4'b0000;
  endtask

  function automatic int den_of(int i);
    case (i)
      0: return 1;
      1: return 2;
      2: return 5;
      default: return 10;
    endcase
  endfunction

  task automatic model_refill();
    for (int i = 0; i < 4; i++) m_inv[i] = INIT;
  endtask

  task automatic model_insert(input logic [3:0] ins);
    for (int i = 0; i < 4; i++) if (ins[i] && m_inv[i] < MAXINV) m_inv[i]++;
  endtask

  // Greedy payout over the current model inventory
  task automatic model_payout(input int chg);
    int rem;
    bit found;
    rem = chg; exp_n = 0; exp_fail = 0;
    while (rem != 0 && !exp_fail) begin
      found = 0;
      for (int i = 3; i >= 0; i--) begin
        if (!found && den_of(i) <= rem && m_inv[i] > 0) begin
          found = 1;
          rem -= den_of(i);
          m_inv[i]--;
          if (exp_n < 128) exp_den[exp_n] = den_of(i);
          exp_n++;
        end
      end
      if (!found) exp_fail = 1;
    end
    exp_rem = rem;
  endtask

  task automatic pulse_inputs(input logic [3:0] coins, input bit refill);
    {bus.i_coin10_p, bus.i_coin5_p, bus.i_coin2_p, bus.i_coin1_p} = coins;
    bus.i_refill = refill;
    tick();
    clr_inputs();
  endtask

  // Drives one payout and records what the DUT does, cycle by cycle, relative
  // to the cycle in which start was presented (rel 0).
  task automatic run_payout(input logic [6:0] chg);
    int rel;
    logic [3:0] ej, prev;
    obs_n = 0; obs_end_rel = -1; obs_end_fail = 0; obs_busy = 0; obs_multi = 0; prev = 0;
    bus.i_start = 1; bus.i_change = chg; bus.i_refill = start_refill;
    tick();
    clr_inputs();
    bus.i_change = 7'($urandom);
    rel = 1;
    while (obs_end_rel < 0 && rel < 600) begin
      ej = {bus.o_eject10, bus.o_eject5, bus.o_eject2, bus.o_eject1};
      if (bus.o_busy) obs_busy++;
      if ($countones(ej) > 1) obs_multi = 1;
      if (ej != 0 && prev == 0 && obs_n < 128) begin
        obs_den[obs_n] = ej[3] ? 10 : ej[2] ? 5 : ej[1] ? 2 : 1;
        obs_start[obs_n] = rel;
        obs_len[obs_n] = 0;
        obs_n++;
      end
      if (ej != 0 && obs_n > 0) obs_len[obs_n-1]++;
      if (bus.o_finish || bus.o_fail) begin
        obs_end_rel = rel;
        obs_end_fail = bus.o_fail;
      end
      prev = ej;
      if (rel == inj_rel) begin
        bus.i_start = inj_start; bus.i_change = inj_change; bus.i_refill = inj_refill;
        {bus.i_coin10_p, bus.i_coin5_p, bus.i_coin2_p, bus.i_coin1_p} = inj_coins;
      end
      tick();
      clr_inputs();
      rel++;
    end
    inj_rel = -1; inj_start = 0; inj_refill = 0; inj_coins = 0; start_refill = 0;
  endtask

  task automatic test_reset();
    rst = 1; clr_inputs(); bus.i_change = 0;
    inj_coins = 0; inj_start = 0; inj_refill = 0; inj_change = 0;
    tick(); tick();
    rst = 0;
    model_refill();
    tests++;
    if ({bus.o_eject10, bus.o_eject5, bus.o_eject2, bus.o_eject1, bus.o_busy, bus.o_finish, bus.o_fail} !== 7'b0) begin
      fails++; $display("FAIL reset_ctrl: ejects/busy/finish/fail=%b want 0", {bus.o_eject10, bus.o_eject5, bus.o_eject2, bus.o_eject1, bus.o_busy, bus.o_finish, bus.o_fail});
    end
    tests++;
    if (bus.o_remaining !== 7'd0) begin
      fails++; $display("FAIL reset_remaining: got %0d want 0", bus.o_remaining);
    end
    tests++;
    if ({bus.o_inv10, bus.o_inv5, bus.o_inv2, bus.o_inv1} !== {4'd5, 4'd5, 4'd5, 4'd5}) begin
      fails++; $display("FAIL reset_inv: got %0d/%0d/%0d/%0d want 5 each", bus.o_inv10, bus.o_inv5, bus.o_inv2, bus.o_inv1);
    end
  endtask

  task automatic test_basic();
    bit bad;
    model_payout(18);
    run_payout(18);
    tests++;
    bad = (obs_n != 4) || obs_multi || (obs_busy != 1 + 4*STEP);
    for (int k = 0; k < 4 && k < obs_n; k++) begin
      if (obs_den[k] != exp_den[k] || obs_start[k] != 2 + k*STEP || obs_len[k] != P) bad = 1;
    end
    if (bad) begin
      fails++; $display("FAIL basic_trace: coins=%0d busy=%0d first=%0d want coins=4 busy=%0d 10/5/2/1", obs_n, obs_busy, obs_den[0], 1 + 4*STEP);
    end
    tests++;
    if (obs_end_rel != 2 + 4*STEP || obs_end_fail != 0) begin
      fails++; $display("FAIL basic_finish: end at %0d fail=%0d want %0d fail=0", obs_end_rel, obs_end_fail, 2 + 4*STEP);
    end
    tests++;
    if (bus.o_finish !== 1'b0 || bus.o_remaining !== 7'd0) begin
      fails++; $display("FAIL basic_after: finish=%b remaining=%0d want 0/0", bus.o_finish, bus.o_remaining);
    end
    tests++;
    if ({bus.o_inv10, bus.o_inv5, bus.o_inv2, bus.o_inv1} !== {4'd4, 4'd4, 4'd4, 4'd4}) begin
      fails++; $display("FAIL basic_inv: got %0d/%0d/%0d/%0d want 4 each", bus.o_inv10, bus.o_inv5, bus.o_inv2, bus.o_inv1);
    end
  endtask

  task automatic test_zero();
    model_payout(0);
    run_payout(0);
    tests++;
    if (obs_n != 0 || obs_end_rel != 2 || obs_end_fail != 0 || obs_busy != 1) begin
      fails++; $display("FAIL zero_change: coins=%0d end=%0d fail=%0d busy=%0d want 0/2/0/1", obs_n, obs_end_rel, obs_end_fail, obs_busy);
    end
  endtask

  task automatic test_greedy_fail();
    bit bad;
    pulse_inputs(4'b0000, 1'b1);
    model_refill();
    for (int j = 0; j < 10; j++) begin
      model_payout(j < 5 ? 5 : 1);
      run_payout(j < 5 ? 7'd5 : 7'd1);
      tests++;
      if (obs_n != 1 || obs_den[0] != exp_den[0] || obs_end_fail != 0) begin
        fails++; $display("FAIL drain_%0d: coins=%0d den=%0d fail=%0d want 1/%0d/0", j, obs_n, obs_den[0], obs_end_fail, exp_den[0]);
      end
    end
    model_payout(7);
    run_payout(7);
    tests++;
    bad = (obs_n != 3) || obs_multi;
    for (int k = 0; k < 3 && k < obs_n; k++) if (obs_den[k] != 2 || obs_start[k] != 2 + k*STEP) bad = 1;
    if (bad) begin
      fails++; $display("FAIL greedy_trace: coins=%0d want three 2-yuan coins", obs_n);
    end
    tests++;
    if (obs_end_fail != 1 || obs_end_rel != 2 + 3*STEP) begin
      fails++; $display("FAIL greedy_fail: fail=%0d end=%0d want 1/%0d", obs_end_fail, obs_end_rel, 2 + 3*STEP);
    end
    tests++;
    if (bus.o_remaining !== 7'd1 || bus.o_inv2 !== 4'd2 || bus.o_busy !== 1'b0) begin
      fails++; $display("FAIL greedy_state: remaining=%0d inv2=%0d busy=%b want 1/2/0", bus.o_remaining, bus.o_inv2, bus.o_busy);
    end
  endtask

  task automatic test_start_ignored();
    bit bad;
    pulse_inputs(4'b0000, 1'b1);
    model_refill();
    model_payout(18);
    inj_rel = 5; inj_start = 1; inj_change = 7'd50;
    run_payout(18);
    tests++;
    bad = (obs_n != exp_n) || obs_multi || obs_end_fail || (obs_end_rel != 2 + exp_n*STEP);
    for (int k = 0; k < exp_n && k < obs_n; k++) if (obs_den[k] != exp_den[k] || obs_len[k] != P) bad = 1;
    if (bad) begin
      fails++; $display("FAIL start_ignored: coins=%0d end=%0d want %0d/%0d", obs_n, obs_end_rel, exp_n, 2 + exp_n*STEP);
    end
    tests++;
    if (bus.o_busy !== 1'b0 || bus.o_remaining !== 7'd0 || bus.o_inv10 !== 4'(m_inv[3])) begin
      fails++; $display("FAIL start_ignored_after: busy=%b rem=%0d inv10=%0d want 0/0/%0d", bus.o_busy, bus.o_remaining, bus.o_inv10, m_inv[3]);
    end
  endtask

  task automatic test_insert_sat();
    pulse_inputs(4'b0000, 1'b1);
    model_refill();
    for (int j = 0; j < 10; j++) begin
      pulse_inputs(4'b0100, 1'b0);
      model_insert(4'b0100);
    end
    tests++;
    if (bus.o_inv5 !== 4'(m_inv[2])) begin
      fails++; $display("FAIL insert_count: inv5=%0d want %0d", bus.o_inv5, m_inv[2]);
    end
    pulse_inputs(4'b0100, 1'b0);
    model_insert(4'b0100);
    tests++;
    if (bus.o_inv5 !== 4'd15) begin
      fails++; $display("FAIL insert_saturate: inv5=%0d want 15", bus.o_inv5);
    end
    // coin5 insert on the first strobe cycle of eject5
    model_payout(5);
    model_insert(4'b0100);
    inj_rel = 2; inj_coins = 4'b0100;
    run_payout(5);
    tests++;
    if (obs_n != 1 || obs_den[0] != 5 || bus.o_inv5 !== 4'(m_inv[2])) begin
      fails++; $display("FAIL insert_vs_eject: coins=%0d inv5=%0d want 1/%0d", obs_n, bus.o_inv5, m_inv[2]);
    end
    // refill on the first strobe cycle still loses the ejected coin
    model_payout(10);
    model_refill();
    m_inv[3] = INIT - 1;
    inj_rel = 2; inj_refill = 1;
    run_payout(10);
    tests++;
    if ({bus.o_inv10, bus.o_inv5, bus.o_inv2, bus.o_inv1} !== {4'(m_inv[3]), 4'(m_inv[2]), 4'(m_inv[1]), 4'(m_inv[0])}) begin
      fails++; $display("FAIL refill_vs_eject: got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d", bus.o_inv10, bus.o_inv5, bus.o_inv2, bus.o_inv1, m_inv[3], m_inv[2], m_inv[1], m_inv[0]);
    end
  endtask

  task automatic test_random();
    bit bad;
    logic [3:0] ins;
    int chg;
    for (int it = 0; it < 25; it++) begin
      ins = 4'($urandom_range(0, 15));
      pulse_inputs(ins, 1'b0);
      model_insert(ins);
      if ($urandom_range(0, 3) == 0) begin
        start_refill = 1;
        model_refill();
      end
      chg = $urandom_range(0, 99);
      model_payout(chg);
      run_payout(7'(chg));
      tests++;
      bad = (obs_n != exp_n) || obs_multi || (obs_busy != 1 + exp_n*STEP);
      for (int k = 0; k < exp_n && k < obs_n; k++) begin
        if (obs_den[k] != exp_den[k] || obs_start[k] != 2 + k*STEP || obs_len[k] != P) bad = 1;
      end
      if (bad) begin
        fails++; $display("FAIL random_trace_%0d chg=%0d: coins=%0d busy=%0d want coins=%0d busy=%0d", it, chg, obs_n, obs_busy, exp_n, 1 + exp_n*STEP);
      end
      tests++;
      if (obs_end_rel != 2 + exp_n*STEP || obs_end_fail != exp_fail || bus.o_remaining !== 7'(exp_rem)) begin
        fails++; $display("FAIL random_end_%0d chg=%0d: end=%0d fail=%0d rem=%0d want %0d/%0d/%0d", it, chg, obs_end_rel, obs_end_fail, bus.o_remaining, 2 + exp_n*STEP, exp_fail, exp_rem);
      end
      tests++;
      if ({bus.o_inv10, bus.o_inv5, bus.o_inv2, bus.o_inv1} !== {4'(m_inv[3]), 4'(m_inv[2]), 4'(m_inv[1]), 4'(m_inv[0])}) begin
        fails++; $display("FAIL random_inv_%0d: got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d", it, bus.o_inv10, bus.o_inv5, bus.o_inv2, bus.o_inv1, m_inv[3], m_inv[2], m_inv[1], m_inv[0]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int rel;
    int stray;
    pulse_inputs(4'b0000, 1'b1);
    bus.i_start = 1; bus.i_change = 7'd18;
    tick();
    clr_inputs();
    rel = 1;
    while (rel < 2 + P) begin   // advance to the first gap cycle after eject10
      tick();
      rel++;
    end
    rst = 1;
    tick();
    rst = 0;
    model_refill();
    tests++;
    if ({bus.o_eject10, bus.o_eject5, bus.o_eject2, bus.o_eject1, bus.o_busy, bus.o_finish, bus.o_fail} !== 7'b0 || bus.o_remaining !== 7'd0) begin
      fails++; $display("FAIL reset_mid_ctrl: ctrl=%b remaining=%0d want 0/0", {bus.o_eject10, bus.o_eject5, bus.o_eject2, bus.o_eject1, bus.o_busy, bus.o_finish, bus.o_fail}, bus.o_remaining);
    end
    tests++;
    if ({bus.o_inv10, bus.o_inv5, bus.o_inv2, bus.o_inv1} !== {4'd5, 4'd5, 4'd5, 4'd5}) begin
      fails++; $display("FAIL reset_mid_inv: got %0d/%0d/%0d/%0d want 5 each", bus.o_inv10, bus.o_inv5, bus.o_inv2, bus.o_inv1);
    end
    stray = 0;
    for (int c = 0; c < 12; c++) begin
      if ({bus.o_eject10, bus.o_eject5, bus.o_eject2, bus.o_eject1, bus.o_busy, bus.o_finish, bus.o_fail} != 7'b0) stray++;
      tick();
    end
    tests++;
    if (stray != 0) begin
      fails++; $display("FAIL reset_mid_idle: %0d active cycles after reset want 0", stray);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_greedy_fail();
    test_start_ignored();
    test_insert_sat();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
